// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_bank
//  Purpose  : Bank of saturating per-channel event counters plus a cycle
//             counter, with a run/freeze/watchdog FSM, a shadow snapshot
//             register file and a registered readout port.
//  Revision : 1.0  initial release
// ============================================================================
module perf_counter_bank #(
    parameter int          NUM_CH      = 6,
    parameter int          CNT_W       = 32,
    parameter int          CYC_W       = 32,
    parameter int unsigned CYCLE_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              halt,
    input  logic              clear,
    input  logic              snap_req,
    input  logic [3:0]        rd_sel,
    output logic [CYC_W-1:0]  rd_data,
    output logic              snap_valid,
    output logic [NUM_CH-1:0] ovf,
    output logic              timeout,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_FROZEN  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CYC_W-1:0] c_LIMIT   = CYC_W'(CYCLE_LIMIT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt    [NUM_CH];
    logic [CYC_W-1:0]   r_cyc;
    // Entries 0..NUM_CH-1 hold channel snapshots, entry NUM_CH the cycle count
    logic [CYC_W-1:0]   r_shadow [NUM_CH+1];
    logic [NUM_CH-1:0]  r_ovf;
    logic               r_timeout;
    logic               r_snapValid;
    logic [CYC_W-1:0]   r_rdData;

    logic [CNT_W-1:0]   w_cntNext [NUM_CH];
    logic [NUM_CH-1:0]  w_satHit;
    logic [CYC_W-1:0]   w_cycNext;
    logic               w_count;
    logic               w_limitHit;
    logic               w_load;
    logic [CYC_W-1:0]   w_rdMux;

    // A cycle is counted only while running with enable held high
    assign w_count = (r_state == S_RUN) && en;

    // Per-channel saturating increment; an event seen at full scale flags overflow
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_satHit[gi]  = event_in[gi] && (r_cnt[gi] == c_CNT_MAX);
            assign w_cntNext[gi] = (event_in[gi] && !w_satHit[gi])
                                   ? r_cnt[gi] + CNT_W'(1) : r_cnt[gi];
        end
    endgenerate

    // Cycle counter is capped at the watchdog limit
    assign w_cycNext  = (r_cyc < c_LIMIT) ? r_cyc + CYC_W'(1) : r_cyc;
    assign w_limitHit = w_count && (w_cycNext == c_LIMIT);

    // Shadow loads on manual request (IDLE/RUN), on halt, or on the watchdog
    // limit; a RUN-cycle request captures the values after this cycle's update
    assign w_load = w_count ? (snap_req || halt || w_limitHit)
                            : (((r_state == S_IDLE) || (r_state == S_RUN)) && snap_req);

    // Readout mux; selects beyond the cycle-counter slot read as zero
    always_comb begin
        w_rdMux = '0;
        for (int k = 0; k <= NUM_CH; k++) begin
            if (rd_sel == 4'(k)) begin
                w_rdMux = r_shadow[k];
            end
        end
    end

    // Counters, shadow, flags and FSM; reset beats clear, clear beats everything else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_ovf       <= '0;
            r_timeout   <= 1'b0;
            r_snapValid <= 1'b0;
            r_rdData    <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            for (int i = 0; i <= NUM_CH; i++) r_shadow[i] <= '0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_ovf       <= '0;
            r_timeout   <= 1'b0;
            r_snapValid <= 1'b0;
            r_rdData    <= w_rdMux;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            for (int i = 0; i <= NUM_CH; i++) r_shadow[i] <= '0;
        end else begin
            r_rdData    <= w_rdMux;
            r_snapValid <= w_load;

            if (w_count) begin
                for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_cntNext[i];
                r_cyc <= w_cycNext;
                r_ovf <= r_ovf | w_satHit;
            end

            if (w_load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_shadow[i] <= CYC_W'(w_count ? w_cntNext[i] : r_cnt[i]);
                end
                r_shadow[NUM_CH] <= w_count ? w_cycNext : r_cyc;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (en) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (halt) begin
                        // halt wins over a simultaneous watchdog expiry
                        r_state <= S_FROZEN;
                    end else if (w_limitHit) begin
                        r_state   <= S_TIMEOUT;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    // FROZEN and TIMEOUT are left only via clear or reset
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign rd_data    = r_rdData;
    assign snap_valid = r_snapValid;
    assign ovf        = r_ovf;
    assign timeout    = r_timeout;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of event channels (1..15).
REQ-002 SHALL have parameter CNT_W, default 32, event counter width.
REQ-003 SHALL have parameter CYC_W, default 32, cycle counter and rd_data width; CYC_W >= CNT_W.
REQ-004 SHALL have parameter CYCLE_LIMIT, default 100000, watchdog limit; legal range 1..2^CYC_W-1.
REQ-005 SHALL have port clk, input, 1, clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port en, input, 1, counting enable.
REQ-008 SHALL have port event_in, input, NUM_CH, per-channel event strobes, one count per cycle high.
REQ-009 SHALL have port halt, input, 1, processor halt indication.
REQ-010 SHALL have port clear, input, 1, synchronous soft clear.
REQ-011 SHALL have port snap_req, input, 1, manual snapshot request.
REQ-012 SHALL have port rd_sel, input, 4, shadow select: 0..NUM_CH-1 channels, NUM_CH cycle counter.
REQ-013 SHALL have port rd_data, output, CYC_W, registered shadow readout, channels zero-extended.
REQ-014 SHALL have port snap_valid, output, 1, one-cycle pulse after any snapshot load.
REQ-015 SHALL have port ovf, output, NUM_CH, sticky per-channel saturation flags.
REQ-016 SHALL have port timeout, output, 1, sticky watchdog flag.
REQ-017 SHALL have port state, output, 2, FSM state: IDLE=0, RUN=1, FROZEN=2, TIMEOUT=3.

Function
REQ-018 SHALL count only in RUN: cycle counter +1 per cycle, channel i +1 when event_in[i]=1.
REQ-019 IDLE -> RUN on edge where en=1; events in that IDLE cycle are not counted.
REQ-020 RUN -> IDLE on edge where en=0; that cycle is not counted; counters hold.
REQ-021 RUN with halt=1: that cycle's events counted; next state FROZEN; shadow loaded with post-update values on same edge.
REQ-022 RUN where cycle counter increments to CYCLE_LIMIT: next state TIMEOUT, timeout set, shadow auto-loaded as REQ-021.
REQ-023 halt and limit on same edge: FROZEN wins; timeout stays 0.
REQ-024 FROZEN and TIMEOUT SHALL be terminal except via clear or reset; en, halt, snap_req, event_in ignored.
REQ-025 snap_req in IDLE or RUN SHALL load shadow with this cycle's post-update values; ignored otherwise.
REQ-026 snap_valid SHALL be 1 exactly in the cycle after any shadow load (manual or auto), else 0.
REQ-027 Channel counter at 2^CNT_W-1 SHALL hold; event arriving while saturated sets ovf[i]; cycle counter never exceeds CYCLE_LIMIT.
REQ-028 rd_data SHALL equal shadow[rd_sel] one cycle after rd_sel sampled; rd_sel > NUM_CH yields 0.
REQ-029 clear SHALL, from any state, zero counters, shadow, ovf, timeout, snap_valid and enter IDLE; clear beats halt, snap_req, events.
REQ-030 halt outside RUN SHALL have no effect.

Reset
REQ-031 rst_n=0 on a rising edge SHALL zero all counters, shadow, ovf, timeout, snap_valid, rd_data and set state IDLE, mid-operation included.
REQ-032 Reset SHALL have priority over clear and all other inputs.

Verification (NUM_CH=4, CNT_W=8, CYC_W=16, CYCLE_LIMIT=1000 unless stated)
REQ-033 en=1, event_in=4'b0101 for 10 RUN cycles, then halt with event_in=4'b0001 -> state=2, snap_valid single pulse, shadow ch0=11, ch1=0, ch2=10, ch3=0, cycle=11.
REQ-034 event_in[1]=1 for 300 RUN cycles, snap_req -> ch1 reads 0x00FF, ovf=4'b0010, set on 256th event.
REQ-035 CYCLE_LIMIT=20, en=1, no halt -> after 20th RUN cycle state=3, timeout=1, cycle shadow=20; further events ignored.
REQ-036 CYCLE_LIMIT=20, halt on 20th RUN cycle -> state=2, timeout=0, cycle shadow=20.
REQ-037 ch0=5 in RUN, clear with event_in[0]=1 and halt=1 -> next cycle ch0=0, state=0, snap_valid=0.
REQ-038 rd_sel=4 after REQ-033 -> rd_data=0x000B one cycle later; rd_sel=7 -> rd_data=0x0000; rst_n=0 mid-RUN -> all outputs 0 next cycle.
